dist_ram_fifo_ctrl: RTL and testbench

//  Single-clock FIFO, 128 deep by DATA_W wide. Storage is DATA_W columns of RAM128X1D distributed RAM.
//  The block drives the RAM write port and the dual-port read address, and consumes DPO.
//  A registered valid/ready output stage prefetches from the RAM.

---
 rtl/dist_fifo_pkg.sv | 8 +
 rtl/RAM128X1D.sv | 27 ++
 rtl/dist_ram_fifo_mem.sv | 32 +++
 rtl/dist_ram_fifo_ctrl.sv | 113 +++++++++++
 tb/tb_dist_ram_fifo_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/dist_fifo_pkg.sv
// Shared sizing constants for the 128-deep distributed-RAM FIFO.
package dist_fifo_pkg;

    localparam int unsigned DEPTH  = 128;  // words of RAM storage
    localparam int unsigned ADDR_W = 7;    // RAM128X1D address width
    localparam int unsigned CNT_W  = 8;    // holds 0..128 RAM occupancy

endpackage

// File: rtl/RAM128X1D.sv
// Behavioural model of the RAM128X1D dual-port distributed RAM primitive.
// Synchronous write on WCLK through port A; asynchronous reads on A (SPO) and DPRA (DPO).
// Ports: WCLK, WE, A[6:0], DPRA[6:0], D, SPO, DPO.
module RAM128X1D (
    input  logic       WCLK,
    input  logic       WE,
    input  logic [6:0] A,
    input  logic [6:0] DPRA,
    input  logic       D,
    output logic       SPO,
    output logic       DPO
);

    logic mem [0:127];

    // Write port
    always_ff @(posedge WCLK) begin
        if (WE) begin
            mem[A] <= D;
        end
    end

    // Asynchronous read ports
    assign SPO = mem[A];
    assign DPO = mem[DPRA];

endmodule

// File: rtl/dist_ram_fifo_mem.sv
// FIFO storage: DATA_W columns of RAM128X1D sharing write and read addresses.
// Ports: WCLK, WE, A (write address), DPRA (read address), D (write word), DPO (read word).
module dist_ram_fifo_mem
    import dist_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              WCLK,
    input  logic              WE,
    input  logic [ADDR_W-1:0] A,
    input  logic [ADDR_W-1:0] DPRA,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] DPO
);

    // SPO mirrors the write address and is not needed by the FIFO
    logic [DATA_W-1:0] spo_unused;

    // One single-bit RAM column per data bit
    for (genvar gi = 0; gi < int'(DATA_W); gi++) begin : g_col
        RAM128X1D u_ram (
            .WCLK (WCLK),
            .WE   (WE),
            .A    (A),
            .DPRA (DPRA),
            .D    (D[gi]),
            .SPO  (spo_unused[gi]),
            .DPO  (DPO[gi])
        );
    end

endmodule

// File: rtl/dist_ram_fifo_ctrl.sv
// Single-clock FIFO controller over 128 x DATA_W distributed RAM with a prefetching
// valid/ready output register.
// Ports: CLK, RST (sync, active-high), WR_EN/WR_DATA (producer), FULL/AFULL/OVF (flags),
//        RD_VALID/RD_READY/RD_DATA (consumer), LEVEL (RAM occupancy + output register).
module dist_ram_fifo_ctrl
    import dist_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned AFULL_THR = 112
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WR_EN,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              FULL,
    output logic              AFULL,
    output logic              OVF,
    output logic              RD_VALID,
    input  logic              RD_READY,
    output logic [DATA_W-1:0] RD_DATA,
    output logic [7:0]        LEVEL
);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THR);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full_q, full_d;
    logic              afull_q, afull_d;
    logic              ovf_q, ovf_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              wr_acc;
    logic              pf;
    logic              pop;
    logic [DATA_W-1:0] dpo;

    dist_ram_fifo_mem #(
        .DATA_W (DATA_W)
    ) u_mem (
        .WCLK (CLK),
        .WE   (wr_acc),
        .A    (wr_ptr_q),
        .DPRA (rd_ptr_q),
        .D    (WR_DATA),
        .DPO  (dpo)
    );

    // Handshakes; prefetch refills the output register whenever it is empty or draining
    assign wr_acc = WR_EN & ~full_q;
    assign pop    = rd_valid_q & RD_READY;
    assign pf     = (cnt_q != '0) & (~rd_valid_q | RD_READY);

    // Next-state for pointers, occupancy, flags and output register
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end

        if (pf) begin
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            rd_data_d  = dpo;
            rd_valid_d = 1'b1;
        end else if (pop) begin
            rd_valid_d = 1'b0;
        end

        cnt_d   = cnt_q + CNT_W'(wr_acc) - CNT_W'(pf);
        full_d  = (cnt_d == FULL_CNT);
        afull_d = (cnt_d >= AFULL_CNT);
        ovf_d   = WR_EN & full_q;
    end

    // State registers; RAM contents are deliberately left untouched by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign FULL     = full_q;
    assign AFULL    = afull_q;
    assign OVF      = ovf_q;
    assign RD_VALID = rd_valid_q;
    assign RD_DATA  = rd_data_q;
    // Max 128 + 1 = 129 fits in 8 bits
    assign LEVEL    = cnt_q + CNT_W'(rd_valid_q);

endmodule

// File: tb/tb_dist_ram_fifo_ctrl.sv
// Directed self-checking bench for dist_ram_fifo_ctrl.
module tb_dist_ram_fifo_ctrl;

    logic       CLK;
    logic       RST;
    logic       WR_EN;
    logic [7:0] WR_DATA;
    logic       FULL;
    logic       AFULL;
    logic       OVF;
    logic       RD_VALID;
    logic       RD_READY;
    logic [7:0] RD_DATA;
    logic [7:0] LEVEL;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;
    logic [7:0] exp_q[$];

    dist_ram_fifo_ctrl #(
        .DATA_W    (8),
        .AFULL_THR (112)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .WR_EN    (WR_EN),
        .WR_DATA  (WR_DATA),
        .FULL     (FULL),
        .AFULL    (AFULL),
        .OVF      (OVF),
        .RD_VALID (RD_VALID),
        .RD_READY (RD_READY),
        .RD_DATA  (RD_DATA),
        .LEVEL    (LEVEL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive one cycle; score any handshake and record any accepted write
    task automatic step(input logic wr, input logic [7:0] d, input logic rdy);
        WR_EN    = wr;
        WR_DATA  = d;
        RD_READY = rdy;
        if (RD_VALID && rdy) begin
            check("pop_has_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check("rd_data_order", 32'(RD_DATA), 32'(exp_q.pop_front()));
            end
            n_out++;
        end
        if (wr && !FULL) begin
            exp_q.push_back(d);
        end
        tick();
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        WR_EN    = 1'b0;
        WR_DATA  = '0;
        RD_READY = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while ((exp_q.size() > 0 || RD_VALID) && guard < 400) begin
            step(1'b0, 8'h00, 1'b1);
            guard++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_level0"}, 32'(LEVEL), 32'd0);
        check({tag, "_valid0"}, 32'(RD_VALID), 32'd0);
    endtask

    initial begin
        int   out_start;
        int   max_lvl;
        int   guard;
        logic [7:0] seq;

        RST      = 1'b1;
        WR_EN    = 1'b0;
        WR_DATA  = '0;
        RD_READY = 1'b0;
        do_reset();

        // Reset state
        check("rst_full",     32'(FULL),     32'd0);
        check("rst_afull",    32'(AFULL),    32'd0);
        check("rst_ovf",      32'(OVF),      32'd0);
        check("rst_rd_valid", 32'(RD_VALID), 32'd0);
        check("rst_rd_data",  32'(RD_DATA),  32'd0);
        check("rst_level",    32'(LEVEL),    32'd0);

        // 1: single write, no bypass, appears one edge later
        step(1'b1, 8'h11, 1'b0);
        check("t1_valid_k",   32'(RD_VALID), 32'd0);
        check("t1_level_k",   32'(LEVEL),    32'd1);
        step(1'b0, 8'h00, 1'b0);
        check("t1_valid_k1",  32'(RD_VALID), 32'd1);
        check("t1_data_k1",   32'(RD_DATA),  32'h11);
        check("t1_level_k1",  32'(LEVEL),    32'd1);

        // 2: fill 129 words with consumer stalled
        do_reset();
        for (int i = 0; i < 129; i++) begin
            step(1'b1, 8'(i), 1'b0);
            check("t2_level", 32'(LEVEL), 32'(i + 1));
            check("t2_afull", 32'(AFULL), 32'((i + 1) >= 113));
            check("t2_full",  32'(FULL),  32'(i == 128));
        end

        // 3: overflow attempt while full
        step(1'b1, 8'hAA, 1'b0);
        check("t3_ovf_pulse",  32'(OVF),   32'd1);
        check("t3_level_hold", 32'(LEVEL), 32'd129);
        step(1'b0, 8'h00, 1'b0);
        check("t3_ovf_clear",  32'(OVF),   32'd0);
        check("t3_level_hold2", 32'(LEVEL), 32'd129);
        out_start = n_out;
        drain("t3");
        check("t3_out_count", 32'(n_out - out_start), 32'd129);

        // 4: 300-word streaming across pointer wrap
        out_start = n_out;
        max_lvl   = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 8'(i * 7 + 3), 1'b1);
            if (int'(LEVEL) > max_lvl) max_lvl = int'(LEVEL);
        end
        drain("t4");
        check("t4_level_le2",  32'(max_lvl <= 2), 32'd1);
        check("t4_out_count",  32'(n_out - out_start), 32'd300);

        // 5: random consumer stalls until full, then drain
        seq   = 8'h00;
        guard = 0;
        while (!FULL && guard < 2000) begin
            step(1'b1, seq, 1'($urandom_range(0, 1)));
            seq = seq + 8'd1;
            guard++;
        end
        check("t5_reached_full", 32'(FULL),  32'd1);
        check("t5_full_level",   32'(LEVEL), 32'd129);
        step(1'b0, 8'h00, 1'b1);
        check("t5_full_drops",   32'(FULL),  32'd0);
        check("t5_level_128",    32'(LEVEL), 32'd128);
        drain("t5");

        // 6: reset with data held in RAM and output register
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 8'(8'hC0 + i), 1'b0);
        end
        check("t6_pre_level", 32'(LEVEL),    32'd50);
        check("t6_pre_valid", 32'(RD_VALID), 32'd1);
        RST   = 1'b1;
        WR_EN = 1'b0;
        tick();
        check("t6_level",  32'(LEVEL),    32'd0);
        check("t6_valid",  32'(RD_VALID), 32'd0);
        check("t6_full",   32'(FULL),     32'd0);
        check("t6_afull",  32'(AFULL),    32'd0);
        RST = 1'b0;
        exp_q.delete();
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("t6_first_valid", 32'(RD_VALID), 32'd1);
        check("t6_first_data",  32'(RD_DATA),  32'h5A);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
